// File: rtl/crf_pkg.sv
// crf_pkg: shared defaults, leaf word layout and FSM encoding for the CRF node store
package crf_pkg;
  localparam int CRF_DATA_W = 32;
  localparam int CRF_LEAF_WORDS = 3;
  localparam int LEAF_FEAT = 0;
  localparam int LEAF_OFFS = 1;
  localparam int LEAF_MULT = 2;
  typedef enum logic [1:0] {IDLE, FETCH, RESP} crfState_t;
endpackage

// File: rtl/crf_node_mem_if.sv
// crf_node_mem_if: loader write, stage read-request and read-response channels
interface crf_node_mem_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int LEAF_WORDS = 3
);
  logic clr;
  logic wr_valid, wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic rq_valid, rq_ready;
  logic [ADDR_W-1:0] rq_addr;
  logic rq_leaf;
  logic rs_valid, rs_ready;
  logic [LEAF_WORDS*DATA_W-1:0] rs_data;
  logic rs_err;
  modport master (
    output clr, wr_valid, wr_addr, wr_data, rq_valid, rq_addr, rq_leaf, rs_ready,
    input wr_ready, rq_ready, rs_valid, rs_data, rs_err
  );
  modport slave (
    input clr, wr_valid, wr_addr, wr_data, rq_valid, rq_addr, rq_leaf, rs_ready,
    output wr_ready, rq_ready, rs_valid, rs_data, rs_err
  );
endinterface

// File: rtl/crf_mem_array.sv
// crf_mem_array: 1R1W word array with registered read and per-entry valid bits
module crf_mem_array #(
  parameter int DATA_W = 32,
  parameter int STAGE = 5,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic [ADDR_W:0]   rdAddr,
  output logic [DATA_W-1:0] rdData,
  output logic              rdHit
);
  localparam int DEPTH = 2**STAGE - 1;
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0] validBits;
  logic wrIn, rdIn;
  assign wrIn = {1'b0, wrAddr} < LIMIT;
  assign rdIn = rdAddr < LIMIT;
  // storage carries no reset so it can map onto a vendor RAM macro
  always_ff @(posedge clk) begin
    if (wrEn && wrIn) mem[wrAddr[STAGE-1:0]] <= wrData;
    rdData <= mem[rdAddr[STAGE-1:0]];
  end
  // write follows clr so a same-cycle write keeps its valid bit
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      validBits <= '0;
      rdHit <= 1'b0;
    end else begin
      if (clr) validBits <= '0;
      if (wrEn && wrIn) validBits[wrAddr[STAGE-1:0]] <= 1'b1;
      rdHit <= rdIn && validBits[rdAddr[STAGE-1:0]] && !clr;
    end
endmodule

// File: rtl/crf_node_mem.sv
// crf_node_mem: valid/ready threshold and leaf store feeding one CRF stage pipeline
module crf_node_mem
  import crf_pkg::*;
#(
  parameter int DATA_W = CRF_DATA_W,
  parameter int STAGE = 5,
  parameter int ADDR_W = 8,
  parameter int LEAF_WORDS = CRF_LEAF_WORDS
) (
  input logic clk,
  input logic rst,
  crf_node_mem_if.slave bus
);
  localparam int CNT_W = $clog2(LEAF_WORDS + 1);
  localparam logic [CNT_W-1:0] LEAF_LAST = CNT_W'(LEAF_WORDS);
  crfState_t state;
  logic [CNT_W-1:0] cnt, lastCnt, capIdx;
  logic [ADDR_W-1:0] baseAddr;
  logic [ADDR_W:0] rdAddr;
  logic [DATA_W-1:0] rdData, rdWord;
  logic [LEAF_WORDS*DATA_W-1:0] rsData;
  logic leafMode, rqFire, wrFire, rdHit, rsValid, rsErr;
  assign bus.wr_ready = !rst && state != FETCH;
  assign bus.rq_ready = !rst && state == IDLE && !bus.wr_valid;
  assign bus.rs_valid = rsValid;
  assign bus.rs_data = rsData;
  assign bus.rs_err = rsErr;
  assign wrFire = bus.wr_valid && bus.wr_ready;
  assign rqFire = bus.rq_valid && bus.rq_ready;
  assign lastCnt = leafMode ? LEAF_LAST : CNT_W'(1);
  assign capIdx = cnt - CNT_W'(1);
  // wider sum so base+k past the top of the address space reads as out of range
  assign rdAddr = {1'b0, baseAddr} + (ADDR_W+1)'(cnt);
  assign rdWord = rdHit ? rdData : '0;
  crf_mem_array #(.DATA_W(DATA_W), .STAGE(STAGE), .ADDR_W(ADDR_W)) memArray (
    .clk(clk), .rst(rst), .clr(bus.clr),
    .wrEn(wrFire), .wrAddr(bus.wr_addr), .wrData(bus.wr_data),
    .rdAddr(rdAddr), .rdData(rdData), .rdHit(rdHit)
  );
  // cnt issues word cnt while capturing word cnt-1 from the registered read
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      baseAddr <= '0;
      leafMode <= 1'b0;
      rsValid <= 1'b0;
      rsData <= '0;
      rsErr <= 1'b0;
    end else begin
      case (state)
        IDLE: if (rqFire) begin
          state <= FETCH;
          cnt <= '0;
          baseAddr <= bus.rq_addr;
          leafMode <= bus.rq_leaf;
          rsData <= '0;
          rsErr <= 1'b0;
        end
        FETCH: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt != '0) begin
            for (int k = 0; k < LEAF_WORDS; k++)
              if (capIdx == CNT_W'(k)) rsData[k*DATA_W +: DATA_W] <= rdWord;
            rsErr <= rsErr || !rdHit;
          end
          if (cnt == lastCnt) begin
            state <= RESP;
            rsValid <= 1'b1;
          end
        end
        RESP: if (bus.rs_ready) begin
          state <= IDLE;
          rsValid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/crf_node_mem.md
Name: crf_node_mem

Overview:
Synchronous, parametrised threshold/leaf store for the Compact Random Forest classifier. It holds per-stage node thresholds (single-word reads) and leaf records (LEAF_WORDS consecutive words: feature index, offset factor, multiply factor). It replaces the asynchronous per-stage SRAM cells. It sits between the training loader (write side) and one CRF stage pipeline (read side), with valid/ready handshakes on every interface.

Parameters:
DATA_W, 32, width of one stored word
STAGE, 5, tree stage; DEPTH = 2^STAGE - 1 words (derived localparam)
ADDR_W, 8, address width; must satisfy 2^ADDR_W >= DEPTH
LEAF_WORDS, 3, words per leaf record

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
clr  in  1  synchronous pulse; invalidates all entries
wr_valid  in  1  write request
wr_ready  out  1  write accepted when wr_valid&wr_ready
wr_addr  in  ADDR_W  write word address
wr_data  in  DATA_W  write data
rq_valid  in  1  read request
rq_ready  out  1  read request accepted
rq_addr  in  ADDR_W  base word address
rq_leaf  in  1  0=node read (1 word), 1=leaf read (LEAF_WORDS words)
rs_valid  out  1  response valid
rs_ready  in  1  response consumed
rs_data  out  LEAF_WORDS*DATA_W  word k at bits [k*DATA_W +: DATA_W]; node read uses word 0, upper words zero
rs_err  out  1  out-of-range or unwritten entry touched

Behaviour:
- Reset (async, rst=1): FSM=IDLE, rs_valid=0, rs_data=0, rs_err=0, all entry-valid bits=0. wr_ready and rq_ready are combinational and 0 during reset. Array contents are not reset.
- FSM states: IDLE, FETCH, RESP.
- IDLE: rq_ready=1 unless wr_valid=1 (write priority); wr_ready=1. Request accepted -> latch addr/mode, word counter=0, go to FETCH.
- FETCH: reads one word per cycle into rs_data slot[counter] and ORs rs_err. Ends after 1 word (node) or LEAF_WORDS words (leaf), then goes to RESP. Latency from accept to rs_valid: 2 cycles for a node read, LEAF_WORDS+1 cycles for a leaf read.
- RESP: rs_valid=1; data is held stable until rs_ready. On rs_valid&rs_ready -> IDLE (no back-to-back acceptance in the same cycle). rs_valid is deasserted the cycle after the handshake.
- Writes: accepted only in IDLE or RESP (wr_ready=0 in FETCH to keep the record atomic). Write of in-range addr stores data and sets valid bit. Write with addr >= DEPTH is accepted and dropped with no effect.
- Error: rs_err=1 if any word address >= DEPTH or its valid bit is 0. Erroneous slots read as zero; other slots return their real data.
- Address wrap: none; addr+k computed at ADDR_W+1 bits so overflow counts as out of range.
- clr: clears all valid bits next edge. If asserted in FETCH, remaining words fetched after clr report error. A response already in RESP is unaffected. clr and a write in the same cycle: the write's valid bit ends set (write wins).
- Reset mid-FETCH/RESP: response is discarded, FSM returns to IDLE, and no rs_valid is generated.

Decomposition:
- Shared package crf_pkg: DATA_W/LEAF_WORDS defaults, leaf word index constants (LEAF_FEAT=0, LEAF_OFFS=1, LEAF_MULT=2), FSM state encoding.
- One sub-module: crf_mem_array, a 1R1W synchronous word array (registered read, no reset) with its valid-bit vector and clr, so the array can later map to a vendor RAM.

Test Plan:
- Node read: write addr 4 = 0x0000_1234; node read addr 4 -> rs_valid 2 cycles after accept, rs_data word0=0x1234, words1-2=0, rs_err=0.
- Leaf read: write 10/11/12 = 7, 0x10, 0x3; leaf read addr 10 -> after 4 cycles rs_data = {0x3,0x10,0x7}, rs_err=0.
- Range/unwritten: leaf read addr 29 (DEPTH=31) -> slots 0-1 hold data if written, slot2=0, rs_err=1. After reset, node read addr 0 -> rs_err=1, data 0.
- Backpressure/priority: hold rs_ready=0 for 5 cycles, so rs_data is stable and rq_ready=0. Assert wr_valid and rq_valid together in IDLE, so the write is accepted first and the read on the next cycle returns the new value.
- clr: write addr 3, pulse clr, read addr 3 -> rs_err=1. Pulse clr together with a write to addr 3, then read -> rs_err=0.
- Reset mid-op: assert rst during FETCH of a leaf read -> rs_valid stays 0, FSM returns to IDLE, and all valid bits read as cleared.
